data_memory_param: RTL

- Parametrised single-port data memory; successor to the fixed 256x8 data memory.
- Adds configurable width and depth, byte-lane write enables, and a valid/ready request interface with a registered 1-cycle response.
- Selectable read-during-write mode, out-of-range detection, and a hardware clear sequencer that zeroes the array after reset or on command.
- Sits between the datapath load/store unit and the memory-mapped peripherals.

---
 rtl/data_memory_param_if.sv | 41 ++++
 rtl/data_memory_param.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/data_memory_param_if.sv
// Request/response bundle for data_memory_param.
//   master: load/store unit side (drives req_*, clr_start)
//   slave : memory side (drives req_ready, rsp_*, err_oob, busy, clr_done)
// Signals:
//   req_valid/req_ready  request handshake, accepted when both are high on clk
//   req_we               1 = write, 0 = read
//   req_addr             word address
//   req_wdata/req_be     write data and byte-lane enables
//   clr_start            one-cycle command to zero the whole array
//   rsp_valid            one-cycle pulse, response for the previous accept
//   rsp_rdata            response data, held until the next response
//   err_oob              pulses with rsp_valid when the address was >= DEPTH
//   busy                 high while the clear sweep runs
//   clr_done             one-cycle pulse after the final clear write
interface data_memory_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  clr_start;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  err_oob;
  logic                  busy;
  logic                  clr_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, clr_start,
    input  req_ready, rsp_valid, rsp_rdata, err_oob, busy, clr_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, clr_start,
    output req_ready, rsp_valid, rsp_rdata, err_oob, busy, clr_done
  );
endinterface

// File: rtl/data_memory_param.sv
// Parametrised single-port data memory with byte-lane writes, a valid/ready
// request port, a registered one-cycle response and a hardware clear sweep.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset (array contents are not reset)
//   s_bus  data_memory_param_if slave modport (request, response, clear status)
module data_memory_param #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_param_if.slave   s_bus
);

  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_CLEAR, S_ACTIVE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_err_oob;
  logic                r_clr_done;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_last;
  logic                w_inr;
  logic                w_ready;
  logic                w_accept;
  logic                w_wr_en;
  logic                w_clr_we;
  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_cidx;
  logic [DATA_W-1:0]   w_old;
  logic [DATA_W-1:0]   w_merged;
  logic [DATA_W-1:0]   w_rsp_data;

  assign w_last   = (32'(r_cnt) == 32'(DEPTH - 1));
  // Full-width compare so DEPTH == 2**ADDR_W never truncates to zero.
  assign w_inr    = (32'(s_bus.req_addr) < 32'(DEPTH));
  assign w_ready  = (r_state == S_ACTIVE) && !s_bus.clr_start && !reset;
  assign w_accept = s_bus.req_valid && w_ready;
  assign w_wr_en  = w_accept && s_bus.req_we && w_inr;
  // Held off during reset so the sweep only writes once it is really running.
  assign w_clr_we = (r_state == S_CLEAR) && !reset;
  assign w_idx    = s_bus.req_addr[IDX_W-1:0];
  assign w_cidx   = r_cnt[IDX_W-1:0];

  // Out-of-range reads never touch the array; the value is masked below.
  assign w_old = w_inr ? r_mem[w_idx] : '0;

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < LANES; i++) begin
      if (s_bus.req_be[i]) w_merged[8*i +: 8] = s_bus.req_wdata[8*i +: 8];
    end
  end

  always_comb begin
    w_rsp_data = '0;
    if (w_inr) begin
      if (s_bus.req_we && (RDW_MODE != 0)) w_rsp_data = w_merged;
      else                                 w_rsp_data = w_old;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_ACTIVE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next state; clr_start inside CLEAR is ignored so the sweep is never
  // restarted by a repeated command.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_CLEAR: begin
        if (w_last) begin
          w_state_nxt = S_ACTIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (s_bus.clr_start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_ACTIVE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Array; the sweep and requests are mutually exclusive because req_ready
  // is low throughout CLEAR.
  always_ff @(posedge clk) begin
    if (w_clr_we)     r_mem[w_cidx] <= '0;
    else if (w_wr_en) r_mem[w_idx]  <= w_merged;
  end

  // Response and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_err_oob   <= 1'b0;
      r_clr_done  <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      r_err_oob   <= w_accept && !w_inr;
      r_clr_done  <= (r_state == S_CLEAR) && w_last;
      if (w_accept) r_rsp_rdata <= w_rsp_data;
    end
  end

  assign s_bus.req_ready = w_ready;
  assign s_bus.rsp_valid = r_rsp_valid;
  assign s_bus.rsp_rdata = r_rsp_rdata;
  assign s_bus.err_oob   = r_err_oob;
  assign s_bus.busy      = (r_state == S_CLEAR);
  assign s_bus.clr_done  = r_clr_done;

endmodule
